// File: rtl/opl3_pkg.sv
// Shared OPL3 definitions: sample type, I2S frame geometry and the slot-to-bit map.
package opl3_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef logic signed [SAMPLE_W-1:0] opl3_sample_t;

    // Philips framing: the MSB sits one bit after the slot boundary, so slot
    // positions 1..16 and 33..48 carry bits 15..0, i.e. index (16 - s) mod 16.
    function automatic logic slot_bit(input logic [5:0] s,
                                      input opl3_sample_t a,
                                      input opl3_sample_t b);
        logic [3:0] idx;
        logic       bit_v;
        idx = 4'd0 - s[3:0];
        if ((s >= 6'd1) && (s <= 6'd16)) begin
            bit_v = a[idx];
        end else if ((s >= 6'd33) && (s <= 6'd48)) begin
            bit_v = b[idx];
        end else begin
            bit_v = 1'b0;
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/opl3_i2s_pump_if.sv
// Sequencer-to-pump sample handshake: ready with a stable A/B pair, rd to restart.
interface opl3_i2s_pump_if;
    import opl3_pkg::*;

    logic         ready;
    opl3_sample_t A;
    opl3_sample_t B;
    logic         rd;

    modport master (output ready, output A, output B, input rd);
    modport slave  (input ready, input A, input B, output rd);

endinterface

// File: rtl/opl3_i2s_clkgen.sv
// Bit-clock divider and 64-slot frame counter; strobes fall events and the frame tick.
module opl3_i2s_clkgen #(
    parameter int BCLK_HALF = 9
) (
    input  logic       clk,
    input  logic       reset,
    output logic       bclk,
    output logic       fall,
    output logic [5:0] s,
    output logic       tick
);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [5:0]       s_q, s_d;
    logic             wrap_s;

    // Next-state for divider, bit clock and slot counter.
    always_comb begin
        wrap_s = (div_q == DIV_W'(BCLK_HALF - 1));
        div_d  = wrap_s ? '0 : (div_q + DIV_W'(1));
        bclk_d = wrap_s ? ~bclk_q : bclk_q;
        fall   = wrap_s & bclk_q;
        s_d    = fall ? (s_q + 6'd1) : s_q;
        tick   = fall & (s_q == 6'd63);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            s_q    <= 6'd0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            s_q    <= s_d;
        end
    end

    assign bclk = bclk_q;
    assign s    = s_q;

endmodule

// File: rtl/opl3_i2s_pump.sv
// Frame-rate consumer of the OPL3 sequencer: latches A/B once per frame, pulses rd,
// and shifts the pair out as Philips I2S.
module opl3_i2s_pump
    import opl3_pkg::*;
#(
    parameter int BCLK_HALF = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    opl3_i2s_pump_if.slave       seq,
    input  logic                 underrun_clr,
    output logic [7:0]           underrun_cnt,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata
);
    logic         bclk_s, fall_s, tick_s;
    logic [5:0]   s_s, s_new_s;
    opl3_sample_t sha_q, sha_d, shb_q, shb_d;
    logic         rd_q, rd_d, lr_q, lr_d, sd_q, sd_d;
    logic [7:0]   cnt_q, cnt_d;

    opl3_i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .bclk  (bclk_s),
        .fall  (fall_s),
        .s     (s_s),
        .tick  (tick_s)
    );

    // Shadow capture, rd strobe, serialiser and underrun bookkeeping.
    always_comb begin
        s_new_s = s_s + 6'd1;
        sha_d   = sha_q;
        shb_d   = shb_q;
        lr_d    = lr_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        rd_d    = tick_s & seq.ready;
        if (tick_s && seq.ready) begin
            sha_d = seq.A;
            shb_d = seq.B;
        end else begin
            sha_d = sha_q;
            shb_d = shb_q;
        end
        // Shadows change only when the new slot is 0, which always carries a 0 bit.
        if (fall_s) begin
            lr_d = s_new_s[5];
            sd_d = slot_bit(s_new_s, sha_q, shb_q);
        end else begin
            lr_d = lr_q;
            sd_d = sd_q;
        end
        if (underrun_clr) begin
            cnt_d = 8'd0;
        end else if (tick_s && !seq.ready && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output and shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sha_q <= '0;
            shb_q <= '0;
            rd_q  <= 1'b0;
            lr_q  <= 1'b0;
            sd_q  <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            sha_q <= sha_d;
            shb_q <= shb_d;
            rd_q  <= rd_d;
            lr_q  <= lr_d;
            sd_q  <= sd_d;
            cnt_q <= cnt_d;
        end
    end

    assign seq.rd       = rd_q;
    assign underrun_cnt = cnt_q;
    assign i2s_bclk     = bclk_s;
    assign i2s_lrclk    = lr_q;
    assign i2s_sdata    = sd_q;

endmodule

// File: tb/tb_opl3_i2s_pump.sv
// Bench for opl3_i2s_pump: frame-arithmetic reference model plus directed frame captures.
module tb_opl3_i2s_pump;
    import opl3_pkg::*;

    localparam int H     = 2;
    localparam int FRAME = 128 * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       underrun_clr = 1'b0;
    logic [7:0] underrun_cnt;
    logic       i2s_bclk, i2s_lrclk, i2s_sdata;

    int errors = 0;
    int checks = 0;

    opl3_i2s_pump_if seq_if ();

    opl3_i2s_pump #(.BCLK_HALF(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .seq          (seq_if.slave),
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything follows from the number of clk edges since reset release.
    initial begin
        int          m_n;
        int          m_cnt;
        logic [15:0] m_a, m_b;
        logic        m_rd;
        int          f, s;
        logic        e_bclk, e_lr, e_sd;
        m_n = 0; m_cnt = 0; m_a = '0; m_b = '0; m_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_n = 0; m_cnt = 0; m_a = '0; m_b = '0; m_rd = 1'b0;
            end
            f      = m_n / (2 * H);
            s      = f % 64;
            e_bclk = ((m_n / H) % 2) == 1;
            e_lr   = (s >= 32);
            if (s >= 1 && s <= 16)       e_sd = m_a[16 - s];
            else if (s >= 33 && s <= 48) e_sd = m_b[48 - s];
            else                         e_sd = 1'b0;
            check("pins{bclk,lrclk,sdata,rd,cnt}",
                  {52'd0, i2s_bclk, i2s_lrclk, i2s_sdata, seq_if.rd, underrun_cnt},
                  {52'd0, e_bclk, e_lr, e_sd, m_rd, m_cnt[7:0]});
            if (!reset) begin
                m_n++;
                m_rd = ((m_n % FRAME) == 0) && seq_if.ready;
                if (m_rd) begin
                    m_a = seq_if.A;
                    m_b = seq_if.B;
                end
                if (underrun_clr) m_cnt = 0;
                else if (((m_n % FRAME) == 0) && !seq_if.ready && m_cnt < 255) m_cnt++;
            end
        end
    end

    task automatic wait_lr_fall(output int cycles);
        logic prev;
        bit   found;
        prev = i2s_lrclk; cycles = 0; found = 1'b0;
        while (!found && cycles < FRAME + 64) begin
            @(posedge clk); #1;
            cycles++;
            if (prev === 1'b1 && i2s_lrclk === 1'b0) found = 1'b1;
            prev = i2s_lrclk;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL lrclk_fall_timeout: no lrclk fall within %0d cycles", cycles);
        end
    endtask

    // Samples sdata once per slot, starting now at slot 0.
    task automatic capture(output logic [63:0] bits, input bit chk_rd, input logic exp_rd0);
        int rd_hi;
        bits = '0; rd_hi = 0;
        bits = {bits[62:0], i2s_sdata};
        if (chk_rd) check("rd_after_tick", {63'd0, seq_if.rd}, {63'd0, exp_rd0});
        for (int k = 1; k < 64; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(posedge clk); #1;
                if (seq_if.rd) rd_hi++;
            end
            bits = {bits[62:0], i2s_sdata};
        end
        if (chk_rd) check("rd_rest_of_frame", rd_hi, 64'd0);
    endtask

    initial begin
        logic [63:0] bits;
        logic [15:0] na, nb;
        int          cyc;
        seq_if.ready = 1'b0;
        seq_if.A     = 16'h0000;
        seq_if.B     = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Let one underrun accumulate, then reset mid-frame between clock edges.
        repeat (300) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_pins", {52'd0, i2s_bclk, i2s_lrclk, i2s_sdata, seq_if.rd, underrun_cnt}, 64'd0);
        seq_if.ready = 1'b1;
        seq_if.A     = 16'h8001;
        seq_if.B     = 16'h7FFE;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        capture(bits, 1'b0, 1'b0);
        check("first_frame_zero", bits, 64'd0);

        // Basic transfer.
        wait_lr_fall(cyc);
        capture(bits, 1'b1, 1'b1);
        check("basic_frame", bits, {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0});

        // Underrun: old pair repeats, no rd.
        seq_if.ready = 1'b0;
        seq_if.A     = 16'($urandom);
        seq_if.B     = 16'($urandom);
        wait_lr_fall(cyc);
        capture(bits, 1'b1, 1'b0);
        check("underrun_frame", bits, {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0});
        check("underrun_cnt_1", underrun_cnt, 64'd1);

        // Recovery with a fresh random pair.
        na = 16'($urandom); nb = 16'($urandom);
        seq_if.ready = 1'b1;
        seq_if.A     = na;
        seq_if.B     = nb;
        wait_lr_fall(cyc);
        capture(bits, 1'b1, 1'b1);
        check("recovered_frame", bits, {1'b0, na, 15'h0, 1'b0, nb, 15'h0});
        check("underrun_cnt_hold", underrun_cnt, 64'd1);

        // Clock geometry.
        cyc = 0;
        while (!(i2s_bclk === 1'b0) && cyc < 16) begin @(posedge clk); #1; cyc++; end
        while (!(i2s_bclk === 1'b1) && cyc < 16) begin @(posedge clk); #1; cyc++; end
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (i2s_bclk === 1'b1 && cyc < 16);
        while (i2s_bclk === 1'b0 && cyc < 16) begin @(posedge clk); #1; cyc++; end
        check("bclk_period", cyc, 64'd4);
        wait_lr_fall(cyc);
        wait_lr_fall(cyc);
        check("lrclk_period", cyc, 64'(FRAME));

        // Randomised traffic against the model.
        for (int i = 0; i < 15 * FRAME; i++) begin
            @(posedge clk); #1;
            seq_if.A     = 16'($urandom);
            seq_if.B     = 16'($urandom);
            seq_if.ready = ($urandom_range(0, 3) != 0);
            underrun_clr = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #1;
        underrun_clr = 1'b0;

        // Saturation, then a clear coinciding with an underrun tick.
        seq_if.ready = 1'b0;
        repeat (300 * FRAME) @(posedge clk);
        #1 check("underrun_saturated", underrun_cnt, 64'd255);
        wait_lr_fall(cyc);
        repeat (FRAME - 1) @(posedge clk);
        #1 underrun_clr = 1'b1;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        check("clear_on_tick", underrun_cnt, 64'd0);
        repeat (FRAME + 8) @(posedge clk);
        #1 check("count_after_clear", underrun_cnt, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
